subsoc_wb_si_to_nt: RTL
=======================

SUBSOC_WB_SI_TO_NT -- requirements
Module: subsoc_wb_si_to_nt

Interface
REQ-001 Parameter NT, default 3: number of Wishbone targets, legal range 2..8.
REQ-002 Parameter T_BASE, default {32'h9e000000, 32'h9d000000, 32'h00000000}: NT packed 32-bit base addresses, target 0 in the LSBs.
REQ-003 Parameter T_MASK, default {32'hff000000, 32'hff000000, 32'hff000000}: NT packed 32-bit compare masks.
REQ-004 Parameter TO_CYC, default 255: target timeout in cycles, 16-bit; 0 disables the timeout.
REQ-005 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-006 wb_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 i_wb_cyc_i, i_wb_stb_i, i_wb_we_i  in  1 each  initiator cycle, strobe and write enable.
REQ-008 i_wb_adr_i  in  32  byte address; i_wb_sel_i  in  4  byte selects; i_wb_dat_i  in  32  write data.
REQ-009 i_wb_dat_o  out  32  read data; i_wb_ack_o  out  1  normal termination; i_wb_err_o  out  1  error termination.
REQ-010 t_wb_cyc_o, t_wb_stb_o  out  NT each  one-hot per-target cycle and strobe.
REQ-011 t_wb_adr_o  out  32; t_wb_sel_o  out  4; t_wb_we_o  out  1; t_wb_dat_o  out  32: shared, registered.
REQ-012 t_wb_dat_i  in  NT*32  per-target read data; t_wb_ack_i, t_wb_err_i  in  NT each.
REQ-013 err_cnt_o  out  16  saturating error-termination count; err_adr_o  out  32  address of last error.

Function
REQ-014 Decode: target k hits when (adr & T_MASK[k]) == (T_BASE[k] & T_MASK[k]); lowest matching k wins; no match = unmapped.
REQ-015 FSM states: IDLE, BUSY, RESP; encoding is free.
REQ-016 IDLE: on a sampled cycle with i_wb_cyc_i & i_wb_stb_i, register adr/sel/we/dat and the one-hot select; hit -> BUSY; unmapped -> RESP with error.
REQ-017 BUSY: drive t_wb_cyc_o[k] = t_wb_stb_o[k] = 1 for the selected k only; all other bits stay 0.
REQ-018 BUSY, sampled t_wb_ack_i[k]: capture t_wb_dat_i[k] into i_wb_dat_o, drop target cyc/stb, then -> RESP with ack.
REQ-019 BUSY, sampled t_wb_err_i[k]: -> RESP with error; if ack and err are sampled together, err wins.
REQ-020 Timeout counter clears on entry to BUSY and increments each BUSY cycle.
REQ-021 With TO_CYC != 0 and the counter at TO_CYC-1 with no ack/err sampled: drop target cyc/stb, then -> RESP with error.
REQ-022 An ack or err sampled in the same cycle as timeout expiry takes precedence over the timeout.
REQ-023 Initiator abort (i_wb_cyc_i sampled 0) in BUSY: drop target cyc/stb next cycle, -> IDLE, no ack/err issued, no counter update.
REQ-024 RESP lasts exactly one cycle with exactly one of i_wb_ack_o / i_wb_err_o high, then -> IDLE; i_wb_ack_o and i_wb_err_o are never high together.
REQ-025 Latency: request sampled at edge n, target strobe high from cycle n+1; target ack sampled at edge m, i_wb_ack_o high in cycle m+1 only.
REQ-026 Unmapped access: i_wb_err_o high in the cycle after the request is sampled; no target strobed.
REQ-027 Requests are accepted only in IDLE, so a strobe still high during RESP is not re-issued.
REQ-028 Every error termination (unmapped, target err, timeout) increments err_cnt_o (saturating at 16'hffff) and loads err_adr_o with the registered address.
REQ-029 i_wb_dat_o holds its last captured value outside RESP; write data passes through unmodified.

Reset
REQ-030 Reset asserted, asynchronously: FSM -> IDLE; all t_wb_cyc_o/t_wb_stb_o = 0; i_wb_ack_o = i_wb_err_o = 0; i_wb_dat_o, t_wb_adr_o, t_wb_dat_o, t_wb_sel_o, t_wb_we_o, err_cnt_o, err_adr_o, timeout counter = 0.
REQ-031 Reset asserted mid-transaction: the transfer is abandoned with no response, and no target strobe appears after reset deasserts until a new request.

Verification
REQ-032 Read 0x9d000010, target 1 acks combinationally with 0x12345678 -> only t_wb_stb_o[1] high for 1 cycle; i_wb_ack_o high once, 2 cycles after request; i_wb_dat_o = 0x12345678.
REQ-033 Write 0x00000100 data 0xdeadbeef sel 4'b0011 -> target 0 sees the same adr/dat/sel with we=1; ack returned; no other target strobed.
REQ-034 Access to 0x50000000 (unmapped) -> i_wb_err_o next cycle; err_cnt_o = 1; err_adr_o = 0x50000000; t_wb_stb_o stays 0.
REQ-035 TO_CYC = 4, target 2 never acks -> target stb high exactly 4 cycles, then i_wb_err_o; err_cnt_o increments; an ack at cycle 4 instead yields i_wb_ack_o.
REQ-036 Target asserts ack and err together -> i_wb_err_o only; later, initiator drops cyc mid-BUSY -> target cyc drops next cycle, no response, FSM returns to IDLE.
REQ-037 Assert reset during BUSY -> all outputs 0 immediately, without waiting for a clock edge; a new read after release completes normally.

Source files
------------

// File: rtl/subsoc_wb_si_to_nt_if.sv
// Wishbone bus bundle for the single-initiator to N-target bridge.
// Carries the initiator-side port and the fanned-out target-side port.
interface subsoc_wb_si_to_nt_if #(
  parameter int NT = 3
);
  // initiator side
  logic             i_wb_cyc_i;
  logic             i_wb_stb_i;
  logic             i_wb_we_i;
  logic [31:0]      i_wb_adr_i;
  logic [3:0]       i_wb_sel_i;
  logic [31:0]      i_wb_dat_i;
  logic [31:0]      i_wb_dat_o;
  logic             i_wb_ack_o;
  logic             i_wb_err_o;
  // target side
  logic [NT-1:0]    t_wb_cyc_o;
  logic [NT-1:0]    t_wb_stb_o;
  logic [31:0]      t_wb_adr_o;
  logic [3:0]       t_wb_sel_o;
  logic             t_wb_we_o;
  logic [31:0]      t_wb_dat_o;
  logic [NT*32-1:0] t_wb_dat_i;
  logic [NT-1:0]    t_wb_ack_i;
  logic [NT-1:0]    t_wb_err_i;

  // bridge view
  modport slave (
    input  i_wb_cyc_i, i_wb_stb_i, i_wb_we_i, i_wb_adr_i, i_wb_sel_i, i_wb_dat_i,
    output i_wb_dat_o, i_wb_ack_o, i_wb_err_o,
    output t_wb_cyc_o, t_wb_stb_o, t_wb_adr_o, t_wb_sel_o, t_wb_we_o, t_wb_dat_o,
    input  t_wb_dat_i, t_wb_ack_i, t_wb_err_i
  );

  // environment view: drives the initiator requests and the target responses
  modport master (
    output i_wb_cyc_i, i_wb_stb_i, i_wb_we_i, i_wb_adr_i, i_wb_sel_i, i_wb_dat_i,
    input  i_wb_dat_o, i_wb_ack_o, i_wb_err_o,
    input  t_wb_cyc_o, t_wb_stb_o, t_wb_adr_o, t_wb_sel_o, t_wb_we_o, t_wb_dat_o,
    output t_wb_dat_i, t_wb_ack_i, t_wb_err_i
  );
endinterface

// File: rtl/subsoc_wb_si_to_nt.sv
// Wishbone single-initiator to N-target bridge: address decode, one
// registered transfer at a time, target timeout, error count/address log.
module subsoc_wb_si_to_nt #(
  parameter int              NT     = 3,
  parameter logic [NT*32-1:0] T_BASE = {32'h9e000000, 32'h9d000000, 32'h00000000},
  parameter logic [NT*32-1:0] T_MASK = {32'hff000000, 32'hff000000, 32'hff000000},
  parameter logic [15:0]     TO_CYC = 16'd255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  subsoc_wb_si_to_nt_if.slave         bus,
  output logic [15:0]                 err_cnt_o,
  output logic [31:0]                 err_adr_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [NT-1:0] hit;
  logic [NT-1:0] pick;
  logic [NT-1:0] sel_reg;
  logic [15:0]   to_cnt;
  logic [31:0]   rd_mux;
  logic          ack_hit;
  logic          err_hit;
  logic          to_exp;
  logic [15:0]   err_cnt_inc;

  // per-target address match
  for (genvar gi = 0; gi < NT; gi++) begin : g_dec
    assign hit[gi] = (bus.i_wb_adr_i & T_MASK[gi*32 +: 32]) ==
                     (T_BASE[gi*32 +: 32] & T_MASK[gi*32 +: 32]);
  end

  // lowest matching target wins: isolate the lowest set bit
  assign pick = hit & (~hit + {{(NT-1){1'b0}}, 1'b1});

  // read data from the selected target (select is one-hot)
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NT; k++) begin
      if (sel_reg[k]) rd_mux = rd_mux | bus.t_wb_dat_i[k*32 +: 32];
    end
  end

  assign ack_hit     = |(bus.t_wb_ack_i & sel_reg);
  assign err_hit     = |(bus.t_wb_err_i & sel_reg);
  assign to_exp      = (TO_CYC != 16'd0) && (to_cnt == TO_CYC - 16'd1);
  assign err_cnt_inc = err_cnt_o + {15'd0, (err_cnt_o != 16'hffff)};

  // transfer FSM with registered bus outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state          <= IDLE;
      sel_reg        <= '0;
      to_cnt         <= '0;
      bus.t_wb_cyc_o <= '0;
      bus.t_wb_stb_o <= '0;
      bus.t_wb_adr_o <= '0;
      bus.t_wb_sel_o <= '0;
      bus.t_wb_we_o  <= 1'b0;
      bus.t_wb_dat_o <= '0;
      bus.i_wb_dat_o <= '0;
      bus.i_wb_ack_o <= 1'b0;
      bus.i_wb_err_o <= 1'b0;
      err_cnt_o      <= '0;
      err_adr_o      <= '0;
    end else begin
      bus.i_wb_ack_o <= 1'b0;
      bus.i_wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_wb_cyc_i && bus.i_wb_stb_i) begin
            bus.t_wb_adr_o <= bus.i_wb_adr_i;
            bus.t_wb_sel_o <= bus.i_wb_sel_i;
            bus.t_wb_we_o  <= bus.i_wb_we_i;
            bus.t_wb_dat_o <= bus.i_wb_dat_i;
            sel_reg        <= pick;
            to_cnt         <= '0;
            if (|pick) begin
              state          <= BUSY;
              bus.t_wb_cyc_o <= pick;
              bus.t_wb_stb_o <= pick;
            end else begin
              // unmapped: error straight away, no target touched
              state          <= RESP;
              bus.i_wb_err_o <= 1'b1;
              err_cnt_o      <= err_cnt_inc;
              err_adr_o      <= bus.i_wb_adr_i;
            end
          end
        end
        BUSY: begin
          if (!bus.i_wb_cyc_i) begin
            // initiator abandoned the cycle: silent return to idle
            state          <= IDLE;
            bus.t_wb_cyc_o <= '0;
            bus.t_wb_stb_o <= '0;
          end else if (err_hit || (!ack_hit && to_exp)) begin
            // target error beats a simultaneous ack; timeout only if neither
            state          <= RESP;
            bus.t_wb_cyc_o <= '0;
            bus.t_wb_stb_o <= '0;
            bus.i_wb_err_o <= 1'b1;
            err_cnt_o      <= err_cnt_inc;
            err_adr_o      <= bus.t_wb_adr_o;
          end else if (ack_hit) begin
            state          <= RESP;
            bus.t_wb_cyc_o <= '0;
            bus.t_wb_stb_o <= '0;
            bus.i_wb_ack_o <= 1'b1;
            bus.i_wb_dat_o <= rd_mux;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
